// File: rtl/USBPkg.sv
// Shared USB transaction constants: packet identifiers and transaction FSM state encodings.
package USBPkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_TOKEN     = 3'd1;
    localparam state_t ST_DATA      = 3'd2;
    localparam state_t ST_WAIT_HS   = 3'd3;
    localparam state_t ST_WAIT_DATA = 3'd4;
    localparam state_t ST_SEND_HS   = 3'd5;
    localparam state_t ST_DONE      = 3'd6;

endpackage

// File: rtl/usb_xact_timer.sv
// Response timeout counter: cleared while not waiting, counts each waiting cycle and
// flags expiry once TIMEOUT waiting cycles have elapsed.
module usb_xact_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [15:0] LP_LAST = 16'(TIMEOUT - 1);

    logic [15:0] r_count;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 16'd1;
        end
    end

    // Expiry on the TIMEOUT-th waiting cycle, counting the entry cycle as the first.
    assign o_expired = i_enable && (r_count == LP_LAST);

endmodule

// File: rtl/usb_host_xact.sv
// Host-side USB transaction engine: token, optional data, handshake, per-endpoint data
// toggles, retries on NAK / timeout / bad CRC and STALL termination.
module usb_host_xact
    import USBPkg::*;
#(
    parameter int unsigned DATA_BYTES = 8,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_start,
    input  logic                      i_is_read,
    input  logic [6:0]                i_addr,
    input  logic [3:0]                i_endp,
    input  logic [8*DATA_BYTES-1:0]   i_wr_data,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_success,
    output logic [8*DATA_BYTES-1:0]   o_rd_data,
    output logic                      o_tx_valid,
    input  logic                      i_tx_ready,
    output logic [3:0]                o_tx_pid,
    output logic [6:0]                o_tx_addr,
    output logic [3:0]                o_tx_endp,
    output logic [8*DATA_BYTES-1:0]   o_tx_payload,
    input  logic                      i_rx_valid,
    input  logic [3:0]                i_rx_pid,
    input  logic [8*DATA_BYTES-1:0]   i_rx_payload,
    input  logic                      i_rx_crc_ok
);

    localparam int unsigned LP_W         = 8 * DATA_BYTES;
    localparam logic [3:0]  LP_MAX_RETRY = 4'(MAX_RETRY);

    state_t          r_state;
    logic            r_is_read;
    logic [6:0]      r_addr;
    logic [3:0]      r_endp;
    logic [LP_W-1:0] r_wr_data;
    logic [3:0]      r_retry_cnt;
    logic [15:0]     r_toggle;
    logic [LP_W-1:0] r_rd_data;
    logic            r_success;
    logic            r_wrong_tgl;

    state_t          w_state_nxt;
    logic [3:0]      w_retry_nxt;
    logic [15:0]     w_toggle_nxt;
    logic [LP_W-1:0] w_rd_data_nxt;
    logic            w_success_nxt;
    logic            w_wrong_nxt;
    logic            w_do_retry;
    logic            w_in_wait;
    logic            w_expired;
    logic            w_rx_is_data;
    logic            w_tgl_match;

    assign w_in_wait    = (r_state == ST_WAIT_HS) || (r_state == ST_WAIT_DATA);
    assign w_rx_is_data = (i_rx_pid == PID_DATA0) || (i_rx_pid == PID_DATA1);
    assign w_tgl_match  = ((i_rx_pid == PID_DATA1) == r_toggle[r_endp]);

    usb_xact_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clear   (!w_in_wait),
        .i_enable  (w_in_wait),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_retry_nxt   = r_retry_cnt;
        w_toggle_nxt  = r_toggle;
        w_rd_data_nxt = r_rd_data;
        w_success_nxt = r_success;
        w_wrong_nxt   = r_wrong_tgl;
        w_do_retry    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt   = ST_TOKEN;
                    w_retry_nxt   = '0;
                    w_success_nxt = 1'b0;
                    w_wrong_nxt   = 1'b0;
                end
            end
            ST_TOKEN: begin
                if (i_tx_ready) w_state_nxt = r_is_read ? ST_WAIT_DATA : ST_DATA;
            end
            ST_DATA: begin
                if (i_tx_ready) w_state_nxt = ST_WAIT_HS;
            end
            ST_WAIT_HS: begin
                if (i_rx_valid && !i_rx_crc_ok) begin
                    w_do_retry = 1'b1;
                end else if (i_rx_valid && i_rx_pid == PID_ACK) begin
                    w_toggle_nxt[r_endp] = ~r_toggle[r_endp];
                    w_success_nxt        = 1'b1;
                    w_state_nxt          = ST_DONE;
                end else if (i_rx_valid && i_rx_pid == PID_NAK) begin
                    w_do_retry = 1'b1;
                end else if (i_rx_valid && i_rx_pid == PID_STALL) begin
                    w_success_nxt = 1'b0;
                    w_state_nxt   = ST_DONE;
                end else if (w_expired) begin
                    w_do_retry = 1'b1;
                end
            end
            ST_WAIT_DATA: begin
                if (i_rx_valid && !i_rx_crc_ok) begin
                    w_do_retry = 1'b1;
                end else if (i_rx_valid && w_rx_is_data) begin
                    w_state_nxt = ST_SEND_HS;
                    if (w_tgl_match) begin
                        w_rd_data_nxt        = i_rx_payload;
                        w_toggle_nxt[r_endp] = ~r_toggle[r_endp];
                        w_success_nxt        = 1'b1;
                        w_wrong_nxt          = 1'b0;
                    end else begin
                        // Device missed our previous ACK: acknowledge, drop data, ask again.
                        w_wrong_nxt = 1'b1;
                    end
                end else if (i_rx_valid && i_rx_pid == PID_NAK) begin
                    w_do_retry = 1'b1;
                end else if (i_rx_valid && i_rx_pid == PID_STALL) begin
                    w_success_nxt = 1'b0;
                    w_state_nxt   = ST_DONE;
                end else if (w_expired) begin
                    w_do_retry = 1'b1;
                end
            end
            ST_SEND_HS: begin
                if (i_tx_ready) begin
                    if (r_wrong_tgl) begin
                        w_wrong_nxt = 1'b0;
                        w_do_retry  = 1'b1;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_do_retry) begin
            if (r_retry_cnt < LP_MAX_RETRY) begin
                w_retry_nxt = r_retry_cnt + 4'd1;
                w_state_nxt = ST_TOKEN;
            end else begin
                w_success_nxt = 1'b0;
                w_state_nxt   = ST_DONE;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_is_read   <= 1'b0;
            r_addr      <= '0;
            r_endp      <= '0;
            r_wr_data   <= '0;
            r_retry_cnt <= '0;
            r_toggle    <= '0;
            r_rd_data   <= '0;
            r_success   <= 1'b0;
            r_wrong_tgl <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_retry_cnt <= w_retry_nxt;
            r_toggle    <= w_toggle_nxt;
            r_rd_data   <= w_rd_data_nxt;
            r_success   <= w_success_nxt;
            r_wrong_tgl <= w_wrong_nxt;
            if (r_state == ST_IDLE && i_start) begin
                r_is_read <= i_is_read;
                r_addr    <= i_addr;
                r_endp    <= i_endp;
                r_wr_data <= i_wr_data;
            end
        end
    end

    always_comb begin
        o_tx_valid   = 1'b0;
        o_tx_pid     = '0;
        o_tx_payload = '0;
        case (r_state)
            ST_TOKEN: begin
                o_tx_valid = 1'b1;
                o_tx_pid   = r_is_read ? PID_IN : PID_OUT;
            end
            ST_DATA: begin
                o_tx_valid   = 1'b1;
                o_tx_pid     = r_toggle[r_endp] ? PID_DATA1 : PID_DATA0;
                o_tx_payload = r_wr_data;
            end
            ST_SEND_HS: begin
                o_tx_valid = 1'b1;
                o_tx_pid   = PID_ACK;
            end
            default: begin
                o_tx_valid = 1'b0;
            end
        endcase
    end

    assign o_tx_addr = r_addr;
    assign o_tx_endp = r_endp;
    assign o_busy    = (r_state != ST_IDLE);
    assign o_done    = (r_state == ST_DONE);
    assign o_success = r_success;
    assign o_rd_data = r_rd_data;

endmodule

// File: tb/tb_usb_host_xact.sv
// Directed bench for usb_host_xact: table of transactions against a scripted device,
// plus hand sequences for ready stalls, ignored rx and mid-transaction reset.
module tb_usb_host_xact;
    import USBPkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        is_read;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] wr_data;
    logic        busy;
    logic        done;
    logic        success;
    logic [63:0] rd_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  tx_pid;
    logic [6:0]  tx_addr;
    logic [3:0]  tx_endp;
    logic [63:0] tx_payload;
    logic        rx_valid;
    logic [3:0]  rx_pid;
    logic [63:0] rx_payload;
    logic        rx_crc_ok;

    always #5 clk = ~clk;

    usb_host_xact #(
        .DATA_BYTES (8),
        .MAX_RETRY  (3),
        .TIMEOUT    (10)
    ) dut (
        .i_clock      (clk),
        .i_reset_n    (reset_n),
        .i_start      (start),
        .i_is_read    (is_read),
        .i_addr       (addr),
        .i_endp       (endp),
        .i_wr_data    (wr_data),
        .o_busy       (busy),
        .o_done       (done),
        .o_success    (success),
        .o_rd_data    (rd_data),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready),
        .o_tx_pid     (tx_pid),
        .o_tx_addr    (tx_addr),
        .o_tx_endp    (tx_endp),
        .o_tx_payload (tx_payload),
        .i_rx_valid   (rx_valid),
        .i_rx_pid     (rx_pid),
        .i_rx_payload (rx_payload),
        .i_rx_crc_ok  (rx_crc_ok)
    );

    // r0_* is the device reply to the first attempt, rn_* to every later one; pid 0 = silent.
    typedef struct {
        logic        is_read;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic [63:0] wr_data;
        logic [3:0]  r0_pid;
        logic        r0_crc;
        logic [63:0] r0_pl;
        logic [3:0]  rn_pid;
        logic        rn_crc;
        logic [63:0] rn_pl;
        int          tokens;
        int          acks;
        logic        success;
        logic [3:0]  data_pid;
        logic [63:0] rd;
        int          gap;
    } vec_t;

    vec_t vecs[16];
    int   n_checks = 0;
    int   n_pass   = 0;

    localparam logic [63:0] PA = 64'h0123456789ABCDEF;
    localparam logic [63:0] PC = 64'hCAFEF00D12345678;
    localparam logic [63:0] PX = 64'hDEADBEEF00000001;
    localparam logic [63:0] PY = 64'h5555AAAA12121212;
    localparam logic [63:0] PZ = 64'h0F0F0F0F0F0F0F0F;

    function automatic vec_t mk(input logic rd_op, input logic [6:0] ad, input logic [3:0] ep,
                                input logic [63:0] wd, input logic [3:0] p0, input logic c0,
                                input logic [63:0] l0, input logic [3:0] pn, input logic cn,
                                input logic [63:0] ln, input int tk, input int ak,
                                input logic sc, input logic [3:0] dp, input logic [63:0] er,
                                input int gp);
        vec_t v;
        v.is_read = rd_op; v.addr = ad; v.endp = ep; v.wr_data = wd;
        v.r0_pid = p0; v.r0_crc = c0; v.r0_pl = l0;
        v.rn_pid = pn; v.rn_crc = cn; v.rn_pl = ln;
        v.tokens = tk; v.acks = ak; v.success = sc; v.data_pid = dp; v.rd = er; v.gap = gp;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic run_vec(input int idx);
        vec_t        v;
        int          tokens, acks, cyc, last_tok;
        logic        pend, pend_first, done_seen, got_succ;
        logic [3:0]  dpid;
        logic [63:0] got_rd;
        v = vecs[idx];
        tokens = 0; acks = 0; cyc = 0; last_tok = 0;
        pend = 1'b0; pend_first = 1'b0; done_seen = 1'b0; got_succ = 1'b0;
        dpid = '0; got_rd = '0;
        @(negedge clk);
        start = 1'b1; is_read = v.is_read; addr = v.addr; endp = v.endp; wr_data = v.wr_data;
        @(negedge clk);
        start = 1'b0; wr_data = '0;
        check($sformatf("v%0d_busy", idx), 64'(busy), 64'd1);
        while (!done_seen && cyc < 300) begin
            rx_valid = 1'b0;
            if (pend) begin
                pend       = 1'b0;
                rx_pid     = pend_first ? v.r0_pid : v.rn_pid;
                rx_crc_ok  = pend_first ? v.r0_crc : v.rn_crc;
                rx_payload = pend_first ? v.r0_pl : v.rn_pl;
                rx_valid   = (rx_pid != 4'h0);
            end
            if (done) begin
                done_seen = 1'b1;
                got_succ  = success;
                got_rd    = rd_data;
            end else if (tx_valid) begin
                case (tx_pid)
                    PID_OUT, PID_IN: begin
                        tokens++;
                        if (v.gap != 0 && tokens > 1)
                            check($sformatf("v%0d_gap%0d", idx, tokens), 64'(cyc - last_tok),
                                  64'(v.gap));
                        last_tok = cyc;
                        check($sformatf("v%0d_tokpid", idx), 64'(tx_pid),
                              64'(v.is_read ? PID_IN : PID_OUT));
                        check($sformatf("v%0d_tokaddr", idx), 64'(tx_addr), 64'(v.addr));
                        check($sformatf("v%0d_tokendp", idx), 64'(tx_endp), 64'(v.endp));
                        if (v.is_read) begin
                            pend = 1'b1; pend_first = (tokens == 1);
                        end
                    end
                    PID_DATA0, PID_DATA1: begin
                        dpid = tx_pid;
                        check($sformatf("v%0d_payload", idx), tx_payload, v.wr_data);
                        pend = 1'b1; pend_first = (tokens == 1);
                    end
                    PID_ACK: acks++;
                    default: check($sformatf("v%0d_txpid", idx), 64'(tx_pid), 64'(PID_ACK));
                endcase
            end
            if (!done_seen) begin
                @(negedge clk);
                cyc++;
            end
        end
        rx_valid = 1'b0;
        check($sformatf("v%0d_done_seen", idx), 64'(done_seen), 64'd1);
        check($sformatf("v%0d_tokens", idx), 64'(tokens), 64'(v.tokens));
        check($sformatf("v%0d_acks", idx), 64'(acks), 64'(v.acks));
        check($sformatf("v%0d_success", idx), 64'(got_succ), 64'(v.success));
        if (v.is_read && v.success) check($sformatf("v%0d_rd", idx), got_rd, v.rd);
        if (!v.is_read) check($sformatf("v%0d_datapid", idx), 64'(dpid), 64'(v.data_pid));
        @(negedge clk);
        check($sformatf("v%0d_done_pulse", idx), 64'(done), 64'd0);
        check($sformatf("v%0d_idle", idx), 64'(busy), 64'd0);
    endtask

    initial begin
        vecs[0]  = mk(0, 7'd5, 4'd4, PA, PID_ACK, 1, 0, PID_ACK, 1, 0, 1, 0, 1, PID_DATA0, 0, 0);
        vecs[1]  = mk(0, 7'd5, 4'd4, PZ, PID_ACK, 1, 0, PID_ACK, 1, 0, 1, 0, 1, PID_DATA1, 0, 0);
        vecs[2]  = mk(1, 7'd5, 4'd4, 0, PID_DATA0, 1, PC, PID_DATA0, 1, PC, 1, 1, 1, 0, PC, 0);
        vecs[3]  = mk(1, 7'd5, 4'd2, 0, PID_DATA1, 1, PX, PID_DATA0, 1, PY, 2, 2, 1, 0, PY, 0);
        vecs[4]  = mk(0, 7'd9, 4'd7, PZ, PID_NAK, 1, 0, PID_NAK, 1, 0, 4, 0, 0, PID_DATA0, 0, 0);
        vecs[5]  = mk(1, 7'd9, 4'd7, 0, 4'h0, 1, 0, 4'h0, 1, 0, 4, 0, 0, 0, 0, 11);
        vecs[6]  = mk(0, 7'd9, 4'd7, PA, PID_STALL, 1, 0, PID_STALL, 1, 0, 1, 0, 0, PID_DATA0, 0,
                      0);
        vecs[7]  = mk(0, 7'd9, 4'd7, PA, PID_ACK, 0, 0, PID_ACK, 1, 0, 2, 0, 1, PID_DATA0, 0, 0);
        vecs[8]  = mk(0, 7'd9, 4'd7, PZ, PID_ACK, 1, 0, PID_ACK, 1, 0, 1, 0, 1, PID_DATA1, 0, 0);
        vecs[9]  = mk(1, 7'd5, 4'd2, 0, PID_NAK, 1, 0, PID_DATA1, 1, PX, 2, 1, 1, 0, PX, 0);
        vecs[10] = mk(1, 7'd12, 4'd9, 0, PID_STALL, 1, 0, PID_STALL, 1, 0, 1, 0, 0, 0, 0, 0);
        vecs[11] = mk(1, 7'd12, 4'd9, 0, PID_DATA0, 0, PC, PID_DATA0, 0, PC, 4, 0, 0, 0, 0, 0);
        vecs[12] = mk(0, 7'd12, 4'd9, PA, 4'h0, 1, 0, 4'h0, 1, 0, 4, 0, 0, PID_DATA0, 0, 12);
        vecs[13] = mk(1, 7'd12, 4'd9, 0, PID_DATA1, 1, PX, PID_DATA1, 1, PX, 4, 4, 0, 0, 0, 0);
        vecs[14] = mk(0, 7'd3, 4'd11, PZ, PID_IN, 1, 0, PID_ACK, 1, 0, 2, 0, 1, PID_DATA0, 0, 12);
        vecs[15] = mk(0, 7'd5, 4'd4, PA, PID_ACK, 1, 0, PID_ACK, 1, 0, 1, 0, 1, PID_DATA0, 0, 0);

        reset_n = 1'b0; start = 1'b0; is_read = 1'b0; addr = '0; endp = '0; wr_data = '0;
        tx_ready = 1'b1; rx_valid = 1'b0; rx_pid = '0; rx_payload = '0; rx_crc_ok = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_success", 64'(success), 64'd0);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_pid", 64'(tx_pid), 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        check("rst_tx_payload", tx_payload, 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(i);

        // Encoder stalls the token; an rx pulse while not waiting must be ignored.
        @(negedge clk);
        tx_ready = 1'b0; start = 1'b1; is_read = 1'b1; addr = 7'h33; endp = 4'd0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stall_valid", 64'(tx_valid), 64'd1);
            check("stall_pid", 64'(tx_pid), 64'(PID_IN));
            check("stall_addr", 64'(tx_addr), 64'h33);
            rx_valid = (k == 1); rx_pid = PID_STALL; rx_crc_ok = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0; tx_ready = 1'b1;
        check("stall_still_token", 64'(tx_valid), 64'd1);
        @(negedge clk);
        rx_valid = 1'b1; rx_pid = PID_STALL; rx_crc_ok = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("stall_done", 64'(done), 64'd1);
        check("stall_success", 64'(success), 64'd0);
        @(negedge clk);
        check("stall_idle", 64'(busy), 64'd0);

        // Reset while waiting for the write handshake.
        start = 1'b1; is_read = 1'b0; addr = 7'h05; endp = 4'd3; wr_data = PZ;
        @(negedge clk);
        start = 1'b0;
        check("mid_token", 64'(tx_pid), 64'(PID_OUT));
        @(negedge clk);
        check("mid_data", 64'(tx_pid), 64'(PID_DATA0));
        @(negedge clk);
        check("mid_wait_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_post_done", 64'(done), 64'd0);
        run_vec(15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/usb_host_xact.md
USB_HOST_XACT -- requirements
Module: usb_host_xact

Interface
REQ-001 Parameter DATA_BYTES, default 8: payload bytes per DATA packet, legal range 1..64.
REQ-002 Parameter MAX_RETRY, default 3: retries allowed after the first attempt, legal range 0..15.
REQ-003 Parameter TIMEOUT, default 255: clocks to wait for a device response, legal range 1..65535.
REQ-004 clock  in  1  single clock; all logic rising-edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 start  in  1  one-cycle transaction request; sampled only in IDLE.
REQ-007 is_read  in  1  1 = IN (read), 0 = OUT (write); captured with start.
REQ-008 addr / endp  in  7 / 4  device address and endpoint; captured with start.
REQ-009 wr_data  in  8*DATA_BYTES  write payload; captured with start.
REQ-010 busy  out  1  high from the cycle after an accepted start until done.
REQ-011 done / success  out  1 / 1  done is a one-cycle completion pulse; success is valid while done is high.
REQ-012 rd_data  out  8*DATA_BYTES  read payload; valid while done && success.
REQ-013 tx_valid, tx_ready  out, in  1, 1  packet handshake to the encoder.
REQ-014 tx_pid, tx_addr, tx_endp, tx_payload  out  4, 7, 4, 8*DATA_BYTES  packet fields; held stable while tx_valid && !tx_ready.
REQ-015 rx_valid, rx_pid, rx_payload, rx_crc_ok  in  1, 4, 8*DATA_BYTES, 1  decoded packet from the receiver; rx_valid is a one-cycle pulse.

Function
REQ-016 PIDs SHALL be OUT=0001, IN=1001, DATA0=0011, DATA1=1011, ACK=0010, NAK=1010, STALL=1110.
REQ-017 The FSM SHALL have the states IDLE, TOKEN, DATA, WAIT_HS, WAIT_DATA, SEND_HS and DONE.
REQ-018 IDLE: start SHALL capture all inputs, clear the retry count and enter TOKEN on the next cycle.
REQ-019 TOKEN SHALL drive tx_valid with tx_pid = OUT or IN, plus addr and endp; on tx_valid && tx_ready it SHALL go to DATA for a write or WAIT_DATA for a read.
REQ-020 DATA SHALL drive tx_pid = DATA0 or DATA1 per the per-endpoint toggle bit, with tx_payload = wr_data; on the handshake it SHALL go to WAIT_HS.
REQ-021 In WAIT_HS:
- ACK SHALL flip the toggle, set success = 1 and enter DONE.
- NAK, timeout or rx_crc_ok = 0 SHALL cause a retry.
- STALL SHALL set success = 0 and enter DONE with no retry.
REQ-022 In WAIT_DATA:
- A DATA packet with good CRC and the expected toggle SHALL latch rd_data and flip the toggle.
- A DATA packet with good CRC and the wrong toggle SHALL discard the payload and still be ACKed.
- In both cases the state SHALL become SEND_HS with ACK, and success = 1 SHALL be set only for the expected toggle.
- NAK, timeout, or bad CRC SHALL retry; bad CRC SHALL send no handshake.
- STALL SHALL end the transaction with success = 0.
REQ-023 If the wrong-toggle packet was received, SEND_HS SHALL enter TOKEN as a retry once the ACK has been transmitted; otherwise it SHALL enter DONE.
REQ-024 Retry rule:
- If retry_cnt < MAX_RETRY, increment retry_cnt and re-enter TOKEN.
- Otherwise enter DONE with success = 0.
REQ-025 The timeout counter SHALL clear on entry to WAIT_HS or WAIT_DATA and increment every cycle there. Reaching TIMEOUT SHALL be a timeout. An rx_valid arriving in the same cycle as the timeout SHALL take priority.
REQ-026 Any other rx_pid in a wait state SHALL be ignored, and the counter SHALL keep running.
REQ-027 rx_valid outside the wait states SHALL be ignored.
REQ-028 DONE SHALL assert done for exactly one cycle, then return to IDLE; start is ignored while busy.
REQ-029 The toggle SHALL be stored per endpoint (16 bits, indexed by endp) and shared between IN and OUT.

Reset
REQ-030 While reset_n is low at a clock edge, all outputs SHALL be 0, the state SHALL be IDLE, all toggles and counters SHALL be 0, and rd_data SHALL be 0.
REQ-031 A reset in mid-transaction SHALL abort immediately with no done pulse, and tx_valid SHALL drop on the next edge.

Structure
REQ-032 The PID constants and the state enum SHALL live in USBPkg.
REQ-033 One sub-module, usb_xact_timer, SHALL hold the timeout counter (clear, enable, expired).

Verification
REQ-034 Write to addr 5, endp 4, wr_data 64'h0123456789ABCDEF, device ACKs -> OUT, then DATA0 with that payload, then done with success = 1; toggle[4] = 1.
REQ-035 Read to endp 4 with toggle 0, device returns DATA0 64'hCAFEF00D12345678 with good CRC -> ACK sent, rd_data matches, success = 1.
REQ-036 MAX_RETRY = 3, device NAKs every attempt -> exactly 4 tokens, then done with success = 0.
REQ-037 Read with no response, TIMEOUT = 10 -> the token repeats 11 cycles after each accepted token until retries are exhausted, then success = 0.
REQ-038 Read returns DATA1 while toggle = 0 -> ACK sent, payload discarded, retry; the next DATA0 succeeds.
REQ-039 Assert reset_n = 0 during WAIT_HS -> next cycle busy = 0, tx_valid = 0, no done pulse; a following write completes normally.
